// File: rtl/regfile_pkg.sv
// Register-file geometry shared by the write-side blocks, plus the modular
// index increment used by the round-robin pointer.
package regfile_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 64;
  localparam int NUM_REGS   = 32;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = REG_ADDR_W'(NUM_REGS - 1);

  // Compare against n-1 so non-power-of-two requester counts wrap correctly.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx == n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Round-robin pick: rotate req right by ptr, take the lowest set bit, rotate back.
// Purely combinational, zero latency; no backpressure of its own.
module rr_priority_pick #(
  parameter int NREQ  = 4,
  parameter int PTR_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic [NREQ-1:0]  winner,
  output logic [PTR_W-1:0] winner_idx,
  output logic             any_valid
);

  logic [NREQ-1:0] rot_req;
  logic [NREQ-1:0] rot_win;

  // Doubling the vector makes the rotate exact for any NREQ, not just powers of two.
  assign rot_req = NREQ'({req, req} >> ptr);
  assign rot_win = rot_req & (~rot_req + NREQ'(1));
  assign winner  = NREQ'(({rot_win, rot_win} << ptr) >> NREQ);

  always_comb begin
    winner_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (winner[i]) winner_idx = PTR_W'(i);
    end
  end

  assign any_valid = |req;

endmodule

// File: rtl/regfile_write_arbiter.sv
// Arbitrates the register-file write port among NREQ requesters (round robin + lock).
// Grant is combinational; write reaches the regfile one cycle later. stall blocks all grants.
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter  int NREQ   = 4,
  parameter  int DATA_W = REG_DATA_W,
  parameter  int ADDR_W = REG_ADDR_W,
  localparam int PTR_W  = $clog2(NREQ)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ-1:0]        lock,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  input  logic [NREQ*DATA_W-1:0] req_data,
  input  logic                   stall,
  output logic [NREQ-1:0]        grant,
  output logic                   RegWrite,
  output logic [ADDR_W-1:0]      WriteRegister,
  output logic [DATA_W-1:0]      WriteData,
  output logic [PTR_W-1:0]       owner,
  output logic                   owner_valid
);

  logic [PTR_W-1:0]  ptr;
  logic [PTR_W-1:0]  pick_idx;
  logic [PTR_W-1:0]  win_idx;
  logic [NREQ-1:0]   pick_onehot;
  logic              pick_any;
  logic              lock_hit;
  logic              accept;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  rr_priority_pick #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .req        (req),
    .ptr        (ptr),
    .winner     (pick_onehot),
    .winner_idx (pick_idx),
    .any_valid  (pick_any)
  );

  // An owner that drops req loses its priority in that same cycle.
  assign lock_hit = owner_valid & req[owner];

  always_comb begin
    grant   = '0;
    win_idx = pick_idx;
    if (reset_n && !stall) begin
      if (lock_hit) begin
        grant   = NREQ'(1) << owner;
        win_idx = owner;
      end else if (pick_any) begin
        grant = pick_onehot;
      end
    end
  end

  assign accept = |grant;

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_addr = req_addr[i*ADDR_W +: ADDR_W];
        sel_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr           <= '0;
      owner         <= '0;
      owner_valid   <= 1'b0;
      RegWrite      <= 1'b0;
      WriteRegister <= '0;
      WriteData     <= '0;
    end else if (accept) begin
      ptr           <= PTR_W'(wrap_inc(int'(win_idx), NREQ));
      owner         <= win_idx;
      owner_valid   <= lock[win_idx];
      // Writes to the zero register are consumed but never enabled.
      RegWrite      <= (sel_addr != ADDR_W'(ZERO_REG));
      WriteRegister <= sel_addr;
      WriteData     <= sel_data;
    end else begin
      owner_valid   <= 1'b0;
      RegWrite      <= 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: table of per-cycle vectors with a scoreboard
// of expected write-stage results, plus hand-written reset sequences.
module tb_regfile_write_arbiter;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [3:0]   req;
  logic [3:0]   lock;
  logic [19:0]  req_addr;
  logic [255:0] req_data;
  logic         stall;
  logic [3:0]   grant;
  logic         RegWrite;
  logic [4:0]   WriteRegister;
  logic [63:0]  WriteData;
  logic [1:0]   owner;
  logic         owner_valid;

  int n_cmp = 0;
  int n_bad = 0;

  regfile_write_arbiter #(.NREQ(4), .DATA_W(64), .ADDR_W(5)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .req           (req),
    .lock          (lock),
    .req_addr      (req_addr),
    .req_data      (req_data),
    .stall         (stall),
    .grant         (grant),
    .RegWrite      (RegWrite),
    .WriteRegister (WriteRegister),
    .WriteData     (WriteData),
    .owner         (owner),
    .owner_valid   (owner_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    string      name;
    logic [3:0] req;
    logic [3:0] lock;
    logic       stall;
    logic       z2;
    logic [3:0] exp_grant;
    logic       exp_ov;
  } vec_t;

  typedef struct {
    logic        chk;
    logic        rw;
    logic [4:0]  addr;
    logic [63:0] data;
    logic [1:0]  own;
    logic        ov;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] dat_of(input int i);
    return 64'h0101_0101_0101_0101 * 64'(i + 1);
  endfunction

  function automatic vec_t mk(input string nm, input logic [3:0] r, input logic [3:0] l,
                              input logic s, input logic z, input logic [3:0] g, input logic ov);
    vec_t v;
    v.name = nm; v.req = r; v.lock = l; v.stall = s; v.z2 = z; v.exp_grant = g; v.exp_ov = ov;
    return v;
  endfunction

  task automatic drive_ops(input logic z2);
    for (int i = 0; i < 4; i++) begin
      req_addr[i*5 +: 5]   = 5'(i + 1);
      req_data[i*64 +: 64] = dat_of(i);
    end
    if (z2) begin
      req_addr[10 +: 5]   = 5'd31;
      req_data[128 +: 64] = 64'hDEAD_BEEF;
    end
  endtask

  task automatic apply(input vec_t v);
    exp_t e;
    int   idx;
    @(negedge clk);
    req = v.req; lock = v.lock; stall = v.stall;
    drive_ops(v.z2);
    #1;
    chk({v.name, " grant"}, 64'(grant), 64'(v.exp_grant));
    idx = -1;
    for (int i = 0; i < 4; i++) if (v.exp_grant[i]) idx = i;
    e.chk = (idx >= 0);
    e.rw  = 1'b0; e.addr = '0; e.data = '0; e.own = '0;
    if (idx >= 0) begin
      e.own = 2'(idx);
      if (v.z2 && idx == 2) begin
        e.addr = 5'd31; e.data = 64'hDEAD_BEEF; e.rw = 1'b0;
      end else begin
        e.addr = 5'(idx + 1); e.data = dat_of(idx); e.rw = 1'b1;
      end
    end
    e.ov = v.exp_ov;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({v.name, " RegWrite"}, 64'(RegWrite), 64'(e.rw));
    chk({v.name, " owner_valid"}, 64'(owner_valid), 64'(e.ov));
    if (e.chk) begin
      chk({v.name, " WriteRegister"}, 64'(WriteRegister), 64'(e.addr));
      chk({v.name, " WriteData"}, WriteData, e.data);
      chk({v.name, " owner"}, 64'(owner), 64'(e.own));
    end
  endtask

  initial begin
    reset_n = 1'b0; req = '0; lock = '0; stall = 1'b0;
    req_addr = '0; req_data = '0;

    // Expected grants hand-derived from the pointer sequence they imply.
    vecs.push_back(mk("rr0",      4'b1111, 4'b0000, 0, 0, 4'b0001, 0));
    vecs.push_back(mk("rr1",      4'b1111, 4'b0000, 0, 0, 4'b0010, 0));
    vecs.push_back(mk("rr2",      4'b1111, 4'b0000, 0, 0, 4'b0100, 0));
    vecs.push_back(mk("rr3",      4'b1111, 4'b0000, 0, 0, 4'b1000, 0));
    vecs.push_back(mk("ptr_to3",  4'b0100, 4'b0000, 0, 0, 4'b0100, 0));
    vecs.push_back(mk("wrap_a",   4'b0101, 4'b0000, 0, 0, 4'b0001, 0));
    vecs.push_back(mk("wrap_b",   4'b0101, 4'b0000, 0, 0, 4'b0100, 0));
    vecs.push_back(mk("wrap_c",   4'b0101, 4'b0000, 0, 0, 4'b0001, 0));
    vecs.push_back(mk("lock_a",   4'b0011, 4'b0010, 0, 0, 4'b0010, 1));
    vecs.push_back(mk("lock_b",   4'b0011, 4'b0010, 0, 0, 4'b0010, 1));
    vecs.push_back(mk("lock_c",   4'b0011, 4'b0010, 0, 0, 4'b0010, 1));
    vecs.push_back(mk("lock_drop",4'b0001, 4'b0010, 0, 0, 4'b0001, 0));
    vecs.push_back(mk("xzr",      4'b0100, 4'b0000, 0, 1, 4'b0100, 0));
    vecs.push_back(mk("lock3",    4'b1000, 4'b1000, 0, 0, 4'b1000, 1));
    vecs.push_back(mk("stall_a",  4'b1000, 4'b1000, 1, 0, 4'b0000, 0));
    vecs.push_back(mk("stall_b",  4'b1000, 4'b1000, 1, 0, 4'b0000, 0));
    vecs.push_back(mk("unstall",  4'b1000, 4'b0000, 0, 0, 4'b1000, 0));
    vecs.push_back(mk("idle",     4'b0000, 4'b0000, 0, 0, 4'b0000, 0));
    vecs.push_back(mk("stall_all",4'b1111, 4'b0000, 1, 0, 4'b0000, 0));
    vecs.push_back(mk("after",    4'b1111, 4'b0000, 0, 0, 4'b0001, 0));

    // Power-on reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("rst RegWrite", 64'(RegWrite), 64'd0);
    chk("rst WriteRegister", 64'(WriteRegister), 64'd0);
    chk("rst WriteData", WriteData, 64'd0);
    chk("rst owner", 64'(owner), 64'd0);
    chk("rst owner_valid", 64'(owner_valid), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Reset arriving while a write sits in the output stage.
    @(negedge clk);
    req = 4'b1111; drive_ops(1'b0);
    #1 chk("pre_rst grant", 64'(grant), 64'h1);
    @(posedge clk);
    #1;
    chk("pre_rst RegWrite", 64'(RegWrite), 64'd1);
    chk("pre_rst WriteRegister", 64'(WriteRegister), 64'd1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst RegWrite", 64'(RegWrite), 64'd0);
    chk("mid_rst grant", 64'(grant), 64'd0);
    chk("mid_rst WriteRegister", 64'(WriteRegister), 64'd0);
    @(negedge clk);
    #1 chk("mid_rst grant held", 64'(grant), 64'd0);
    req = '0;
    reset_n = 1'b1;

    foreach (vecs[k]) apply(vecs[k]);

    chk("scoreboard drained", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the single write port of the 32x64 register file among NREQ requesters, for example the ALU writeback, the load unit and the debug/init loader.
- Uses round-robin arbitration with a req/grant handshake and an optional lock for back-to-back ownership.
- Registers the winning address and data, and drives RegWrite/WriteRegister/WriteData into the register file one cycle after the grant.
- Sits between the requesters and the register file's write decoder tree.

Parameters:
- NREQ, default 4: number of requesters, valid range 2..8.
- DATA_W, default 64: write data width.
- ADDR_W, default 5: register address width (32 registers).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req  in  NREQ  req[i]=1 means requester i has a pending write.
- lock  in  NREQ  lock[i]=1 with req[i]=1 asks to keep ownership next cycle.
- req_addr  in  NREQ*ADDR_W  packed; slice i is requester i's destination register.
- req_data  in  NREQ*DATA_W  packed; slice i is requester i's write data.
- stall  in  1  1 = no grant issued this cycle.
- grant  out  NREQ  one-hot, combinational; the write is accepted at the clock edge where grant[i]=1.
- RegWrite  out  1  registered register-file write enable.
- WriteRegister  out  ADDR_W  registered destination address.
- WriteData  out  DATA_W  registered write data.
- owner  out  $clog2(NREQ)  registered index of the last accepted requester.
- owner_valid  out  1  registered; 1 = owner holds a locked grant.

Behaviour:
- Reset (reset_n=0, asynchronous, any time):
  - RegWrite=0, WriteRegister=0, WriteData=0, owner=0, owner_valid=0.
  - Internal priority pointer ptr=0.
- Reset mid-operation: a write in the output stage is dropped; nothing reaches the register file after reset asserts.
- Grant is combinational. No grant is issued if stall=1, reset_n=0 or req=0.
- Locked owner has absolute priority: if owner_valid=1 and req[owner]=1, then grant=onehot(owner).
- Otherwise the round-robin winner is the first i with req[i]=1, scanning ptr, ptr+1, … wrapping mod NREQ.
- At most one grant bit is ever set.
- Handshake:
  - A requester holds req, addr and data stable until it samples grant[i]=1 at a rising edge.
  - Dropping req before the grant is allowed; the request is withdrawn with no side effects.
- Latency: a grant in cycle N produces RegWrite=1 and the captured addr/data in cycle N+1. Every following cycle without a grant gives RegWrite=0.
- Throughput: one write per cycle. Back-to-back grants to different requesters are allowed.
- Zero register:
  - A grant with addr=31 (XZR) is accepted: the grant pulses and ptr advances.
  - RegWrite stays 0 for that write, while WriteRegister/WriteData still update.
- Pointer update on an accepted grant to w:
  - ptr <= (w+1) mod NREQ; owner <= w; owner_valid <= lock[w].
- Pointer update otherwise: no grant (stall, or req=0) leaves ptr and owner unchanged and sets owner_valid <= 0.
- Locked owner that drops req: it loses the lock. Arbitration falls back to round-robin the same cycle and owner_valid clears.
- stall=1 while owner_valid=1: the lock is released (owner_valid <= 0), so a stalled owner does not starve the others.
- NREQ not a power of two: the wrap uses an explicit compare to NREQ-1, never natural overflow.

Decomposition:
- Shared package regfile_pkg: REG_ADDR_W=5, REG_DATA_W=64, NUM_REGS=32, ZERO_REG=5'd31.
- Sub-module rr_priority_pick: combinational.
  - Inputs: req[NREQ], ptr.
  - Outputs: one-hot winner, encoded index, any_valid.
  - Implementation: rotate right by ptr, fixed-priority pick, rotate back.
- Top level: pointer, owner and lock registers, output register stage, zero-register suppression.

Test Plan:
- Reset: drive reset_n=0 mid-write with req=4'b1111 -> RegWrite=0, grant=0 immediately, ptr=0. After release, the first grant goes to req 0.
- Round-robin: req=4'b1111 held for 4 cycles, lock=0 -> grants 0,1,2,3 in order. RegWrite=1 on each following cycle with WriteRegister equal to that requester's addr (for example 1,2,3,4).
- Wrap with a sparse request: ptr=3, req=4'b0101 -> grant to 0, then 2, then 0.
- Lock: req=4'b0011, lock[1]=1 with ptr pointing at 1 -> requester 1 granted 3 consecutive cycles. Requester 1 then drops req -> next grant goes to 0 the same cycle.
- Zero register: requester 2 writes addr=31, data=64'hDEAD_BEEF -> grant[2]=1, and next cycle RegWrite=0, WriteRegister=31.
- Stall: stall=1 for 2 cycles with req=4'b1000 -> grant=0, RegWrite=0, owner_valid=0. Stall drops -> grant[3]=1, and RegWrite=1 one cycle later.
